// File: rtl/tempest_input_pkg.sv
// Shared constants, pending-accumulator type and clamp helper for the spinner input stage.
package tempest_input_pkg;

    localparam int TBC_W        = 4;
    localparam int STEP_DIV_DEF = 1500;
    localparam int JOY_DIV_DEF  = 6000;
    localparam int PEND_W_DEF   = 8;
    localparam int PEND_MAX_DEF = 127;

    typedef logic signed [PEND_W_DEF-1:0] pend_t;

    // Symmetric saturation so a long spin in one direction never wraps the backlog.
    function automatic int clamp_pend(input int v, input int lim);
        if (v > lim)
            return lim;
        else if (v < -lim)
            return -lim;
        return v;
    endfunction

endpackage

// File: rtl/tempest_tick_div.sv
// Modulo-N counter with synchronous clear; tick pulses when the count equals TICK_AT while enabled.
module tempest_tick_div #(
    parameter int N       = 4,
    parameter int TICK_AT = N - 1,
    localparam int W      = (N > 1) ? $clog2(N) : 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    logic [W-1:0] cnt;

    assign tick = en && (cnt == W'(TICK_AT));

    always_ff @(posedge clk) begin
        if (rst || clr)
            cnt <= '0;
        else if (en)
            cnt <= (cnt == W'(N - 1)) ? '0 : cnt + W'(1);
    end

endmodule

// File: rtl/tempest_spinner.sv
// Spinner position counter feeding the POKEY pot inputs: host deltas, joystick and (with
// SPIN_QUAD_EN defined) a raw quadrature encoder accumulate into a backlog drained one step per tick.
module tempest_spinner
    import tempest_input_pkg::*;
#(
    parameter int STEP_DIV = STEP_DIV_DEF,
    parameter int JOY_DIV  = JOY_DIV_DEF,
    parameter int PEND_W   = PEND_W_DEF,
    parameter int PEND_MAX = PEND_MAX_DEF
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [7:0]       SPIN_DELTA,
    input  logic             SPIN_TOGGLE,
    input  logic             JOY_LEFT,
    input  logic             JOY_RIGHT,
`ifdef SPIN_QUAD_EN
    input  logic             QUAD_A,
    input  logic             QUAD_B,
`endif
    output logic [TBC_W-1:0] TBC,
    output logic             SPIN_DIR,
    output logic             SPIN_BUSY
);

    localparam int SW = PEND_W + 2;

    logic                     toggle_q;
    logic signed [PEND_W-1:0] pending;
    logic signed [PEND_W-1:0] pending_next;
    logic signed [7:0]        delta_add;
    logic signed [1:0]        joy_add;
    logic signed [1:0]        quad_add;
    logic signed [1:0]        consume;
    logic signed [SW-1:0]     sum;
    int                       clamped;
    logic                     tick;
    logic                     joy_one;
    logic                     joy_tick;

    tempest_tick_div #(.N(STEP_DIV)) u_step_div (
        .clk  (CLK),
        .rst  (RESET),
        .clr  (1'b0),
        .en   (1'b1),
        .tick (tick)
    );

    // Joystick steps fire on count 0 so the first held cycle already moves the spinner.
    assign joy_one = JOY_LEFT ^ JOY_RIGHT;

    tempest_tick_div #(.N(JOY_DIV), .TICK_AT(0)) u_joy_div (
        .clk  (CLK),
        .rst  (RESET),
        .clr  (~joy_one),
        .en   (joy_one),
        .tick (joy_tick)
    );

`ifdef SPIN_QUAD_EN
    logic [1:0] a_sync;
    logic [1:0] b_sync;
    logic       a_prev;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            a_sync <= '0;
            b_sync <= '0;
            a_prev <= 1'b0;
        end else begin
            a_sync <= {a_sync[0], QUAD_A};
            b_sync <= {b_sync[0], QUAD_B};
            a_prev <= a_sync[1];
        end
    end

    always_comb begin
        quad_add = '0;
        if (a_sync[1] && !a_prev)
            quad_add = b_sync[1] ? -2'sd1 : 2'sd1;
    end
`else
    assign quad_add = '0;
`endif

    always_comb begin
        delta_add = '0;
        if (SPIN_TOGGLE != toggle_q)
            delta_add = SPIN_DELTA;

        joy_add = '0;
        if (joy_tick)
            joy_add = JOY_RIGHT ? 2'sd1 : -2'sd1;

        consume = '0;
        if (tick && pending != '0)
            consume = pending[PEND_W-1] ? -2'sd1 : 2'sd1;

        // Wide enough that the worst-case sum cannot overflow before clamping.
        sum = SW'(pending) + SW'(delta_add) + SW'(joy_add) + SW'(quad_add) - SW'(consume);
        clamped      = clamp_pend(int'(sum), PEND_MAX);
        pending_next = clamped[PEND_W-1:0];
    end

    always_ff @(posedge CLK) begin
        toggle_q <= SPIN_TOGGLE;
        if (RESET) begin
            TBC       <= '0;
            SPIN_DIR  <= 1'b0;
            SPIN_BUSY <= 1'b0;
            pending   <= '0;
        end else begin
            pending   <= pending_next;
            SPIN_BUSY <= (pending_next != '0);
            if (consume == 2'sd1) begin
                TBC      <= TBC + TBC_W'(1);
                SPIN_DIR <= 1'b1;
            end else if (consume == -2'sd1) begin
                TBC      <= TBC - TBC_W'(1);
                SPIN_DIR <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_tempest_spinner.sv
// Directed bench for tempest_spinner with short dividers (STEP_DIV=4, JOY_DIV=8).
module tb_tempest_spinner;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [7:0] SPIN_DELTA;
    logic       SPIN_TOGGLE;
    logic       JOY_LEFT;
    logic       JOY_RIGHT;
    logic [3:0] TBC;
    logic       SPIN_DIR;
    logic       SPIN_BUSY;

    int n_chk = 0;
    int n_bad = 0;

    always #5 CLK = ~CLK;

    tempest_spinner #(
        .STEP_DIV (4),
        .JOY_DIV  (8),
        .PEND_W   (8),
        .PEND_MAX (127)
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .SPIN_DELTA  (SPIN_DELTA),
        .SPIN_TOGGLE (SPIN_TOGGLE),
        .JOY_LEFT    (JOY_LEFT),
        .JOY_RIGHT   (JOY_RIGHT),
`ifdef SPIN_QUAD_EN
        .QUAD_A      (1'b0),
        .QUAD_B      (1'b0),
`endif
        .TBC         (TBC),
        .SPIN_DIR    (SPIN_DIR),
        .SPIN_BUSY   (SPIN_BUSY)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic strobe(input logic [7:0] d);
        SPIN_DELTA  = d;
        SPIN_TOGGLE = ~SPIN_TOGGLE;
    endtask

    // Leaves the bench 1ns after the tick edge on which TBC moved.
    task automatic wait_step(input string tag);
        logic [3:0] old;
        int         k;
        old = TBC;
        k   = 0;
        while (TBC == old && k < 12) begin
            cyc(1);
            k++;
        end
        chk(tag, int'(k < 12), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET       = 1'b1;
        SPIN_TOGGLE = 1'b1;
        SPIN_DELTA  = 8'd5;
        JOY_LEFT    = 1'b0;
        JOY_RIGHT   = 1'b0;
        cyc(3);
        chk("rst_tbc",  int'(TBC), 0);
        chk("rst_busy", int'(SPIN_BUSY), 0);
        chk("rst_dir",  int'(SPIN_DIR), 0);
        RESET = 1'b0;
        cyc(20);
        chk("rel_tbc",  int'(TBC), 0);
        chk("rel_busy", int'(SPIN_BUSY), 0);

        // +3: three steps, one per 4-clock tick
        strobe(8'd3);
        wait_step("p3_step1");
        chk("p3_tbc1", int'(TBC), 1);
        chk("p3_dir",  int'(SPIN_DIR), 1);
        chk("p3_busy", int'(SPIN_BUSY), 1);
        cyc(3);
        chk("p3_hold", int'(TBC), 1);
        cyc(1);
        chk("p3_tbc2", int'(TBC), 2);
        cyc(4);
        chk("p3_tbc3", int'(TBC), 3);
        chk("p3_idle", int'(SPIN_BUSY), 0);

        // back to 0, then -2 wraps through 15 to 14
        strobe(8'hFD);
        cyc(20);
        chk("m3_tbc", int'(TBC), 0);
        strobe(8'hFE);
        wait_step("m2_step1");
        chk("m2_tbc15", int'(TBC), 15);
        chk("m2_dir",   int'(SPIN_DIR), 0);
        cyc(4);
        chk("m2_tbc14", int'(TBC), 14);
        chk("m2_idle",  int'(SPIN_BUSY), 0);

        // two +127 strobes on non-tick cycles saturate at 127: 14+127 = 13 mod 16
        cyc(8);
        strobe(8'd127);
        cyc(1);
        strobe(8'd127);
        cyc(1);
        chk("sat_busy", int'(SPIN_BUSY), 1);
        cyc(520);
        chk("sat_tbc",  int'(TBC), 13);
        chk("sat_idle", int'(SPIN_BUSY), 0);
        SPIN_DELTA = 8'd5;
        cyc(20);
        chk("notgl_tbc",  int'(TBC), 13);
        chk("notgl_busy", int'(SPIN_BUSY), 0);

        // joystick: 32 held clocks at JOY_DIV=8 give 4 steps
        JOY_RIGHT = 1'b1;
        cyc(32);
        JOY_RIGHT = 1'b0;
        cyc(40);
        chk("joyr_tbc",  int'(TBC), 1);
        chk("joyr_busy", int'(SPIN_BUSY), 0);
        chk("joyr_dir",  int'(SPIN_DIR), 1);
        JOY_LEFT = 1'b1;
        cyc(32);
        JOY_LEFT = 1'b0;
        cyc(40);
        chk("joyl_tbc", int'(TBC), 13);
        chk("joyl_dir", int'(SPIN_DIR), 0);
        JOY_LEFT  = 1'b1;
        JOY_RIGHT = 1'b1;
        cyc(32);
        chk("joyb_busy", int'(SPIN_BUSY), 0);
        JOY_LEFT  = 1'b0;
        JOY_RIGHT = 1'b0;
        cyc(20);
        chk("joyb_tbc", int'(TBC), 13);

        // add landing on a consuming tick: both applied
        strobe(8'd2);
        wait_step("sim_step1");
        chk("sim_tbc14", int'(TBC), 14);
        cyc(3);
        chk("sim_hold", int'(TBC), 14);
        strobe(8'd1);
        cyc(1);
        chk("sim_tbc15", int'(TBC), 15);
        chk("sim_busy",  int'(SPIN_BUSY), 1);
        cyc(4);
        chk("sim_tbc0", int'(TBC), 0);
        chk("sim_idle", int'(SPIN_BUSY), 0);

        // reset with pending=5 and TBC=7
        strobe(8'd12);
        wait_step("rm_step1");
        chk("rm_tbc1", int'(TBC), 1);
        cyc(24);
        chk("rm_tbc7",  int'(TBC), 7);
        chk("rm_busy",  int'(SPIN_BUSY), 1);
        RESET = 1'b1;
        cyc(1);
        RESET = 1'b0;
        chk("rm_rst_tbc",  int'(TBC), 0);
        chk("rm_rst_busy", int'(SPIN_BUSY), 0);
        chk("rm_rst_dir",  int'(SPIN_DIR), 0);
        cyc(20);
        chk("rm_after_tbc",  int'(TBC), 0);
        chk("rm_after_busy", int'(SPIN_BUSY), 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
